dijkstra_query_arbiter: RTL

DIJKSTRA_QUERY_ARBITER -- requirements
Module: dijkstra_query_arbiter

---
 rtl/dijkstra_query_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dijkstra_query_arbiter.sv
// Round-robin arbiter that serialises shortest-path queries onto a single engine.
// Optional watchdog on the engine wait: define DIJKSTRA_ARB_TIMEOUT_EN.
module dijkstra_query_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned NODE_W  = 5,
    parameter int unsigned DIST_W  = 14,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*NODE_W-1:0]    req_src,
    input  logic [NREQ*NODE_W-1:0]    req_dst,
    output logic [NREQ-1:0]           gnt,
    output logic                      eng_start,
    output logic [NODE_W-1:0]         eng_src,
    input  logic                      eng_done,
    output logic [NODE_W-1:0]         eng_rd_addr,
    input  logic [DIST_W-1:0]         eng_rd_dist,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [$clog2(NREQ)-1:0]   resp_id,
    output logic [DIST_W-1:0]         resp_dist,
    output logic                      resp_err,
    output logic                      busy
);

    localparam int unsigned ID_W = $clog2(NREQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_READ,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win_id;
    logic            win_any;
    logic            first_wait;
    logic            done_ok;

    // Parameter legality hook; elaborates to nothing for legal settings.
    if (NREQ < 2 || NREQ > 8 || (NREQ & (NREQ - 1)) != 0 || TIMEOUT < 1) begin : g_illegal_params
    end

    // Round-robin search starting at ptr; the lowest offset from ptr wins.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx     = '0;
        win_any = 1'b0;
        win_id  = ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = ptr + ID_W'(i);
            if (req[idx]) begin
                win_any = 1'b1;
                win_id  = idx;
            end
        end
    end

    // A done level seen in the first WAIT cycle is left over from the previous run.
    assign done_ok = eng_done && !first_wait;

`ifdef DIJKSTRA_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd;
    logic            wd_hit;

    assign wd_hit = (wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd <= '0;
        end else if (state == S_LAUNCH) begin
            wd <= '0;
        end else if (state == S_WAIT) begin
            wd <= wd + WD_W'(1);
        end
    end
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (win_any) state_nx = S_LAUNCH;
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT: begin
                if (done_ok) begin
                    state_nx = S_READ;
                end
`ifdef DIJKSTRA_ARB_TIMEOUT_EN
                else if (wd_hit) begin
                    state_nx = S_RESP;
                end
`endif
            end
            S_READ:   state_nx = S_RESP;
            S_RESP:   if (resp_ready) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Registered outputs and query latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt         <= '0;
            eng_start   <= 1'b0;
            eng_src     <= '0;
            eng_rd_addr <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_dist   <= '0;
            busy        <= 1'b0;
            ptr         <= '0;
            first_wait  <= 1'b0;
        end else begin
            gnt        <= '0;
            eng_start  <= 1'b0;
            busy       <= (state_nx != S_IDLE);
            resp_valid <= (state_nx == S_RESP);
            first_wait <= (state == S_LAUNCH);
            if (state == S_IDLE && win_any) begin
                gnt         <= NREQ'(1) << win_id;
                eng_start   <= 1'b1;
                eng_src     <= req_src[32'(win_id) * NODE_W +: NODE_W];
                eng_rd_addr <= req_dst[32'(win_id) * NODE_W +: NODE_W];
                resp_id     <= win_id;
                ptr         <= win_id + ID_W'(1);
            end
            if (state == S_READ) begin
                resp_dist <= eng_rd_dist;
            end
`ifdef DIJKSTRA_ARB_TIMEOUT_EN
            if (state == S_WAIT && !done_ok && wd_hit) begin
                resp_dist <= '1;
            end
`endif
        end
    end

`ifdef DIJKSTRA_ARB_TIMEOUT_EN
    // Error flag is set only by an expired watchdog and cleared by a normal read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_err <= 1'b0;
        end else if (state == S_READ) begin
            resp_err <= 1'b0;
        end else if (state == S_WAIT && !done_ok && wd_hit) begin
            resp_err <= 1'b1;
        end
    end
`else
    assign resp_err = 1'b0;
`endif

endmodule
